// File: rtl/cp0_reg.sv
// rtl/cp0_reg.sv - MIPS CP0 register file: Count/Compare timer, Status/Cause/EPC/BadVAddr, exception capture
package cp0_pkg;
  typedef struct packed {
    logic Interrupt;
    logic WrongAddressinIF;
    logic ReservedInstruction;
    logic Syscall;
    logic Break;
    logic Eret;
    logic Overflow;
    logic WrWrongAddressinMEM;
    logic RdWrongAddressinMEM;
  } ExceptinPipeType;
endpackage

module cp0_reg
  import cp0_pkg::*;
#(
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            WB_CP0RegWr_i,
  input  logic [4:0]      WB_CP0RegWrAddr_i,
  input  logic [31:0]     WB_CP0RegWrData_i,
  input  logic [4:0]      CP0RegRdAddr_i,
  output logic [31:0]     CP0RegRdData_o,
  input  ExceptinPipeType ExceptType_i,
  input  logic [31:0]     CurrentPC_i,
  input  logic            IsInDelaySlot_i,
  input  logic [31:0]     BadVAddr_i,
  input  logic [5:0]      Interrupt_i,
  output logic [31:0]     CP0Status_o,
  output logic [31:0]     CP0Cause_o,
  output logic [31:0]     CP0EPC_o,
  output logic [31:0]     CP0BadVAddr_o,
  output logic            Timer_int_o
);

  localparam logic [4:0]  REG_BADVADDR = 5'd8;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  typedef enum logic [1:0] {BVA_KEEP, BVA_PC, BVA_DATA} bva_sel_t;

  logic [31:0] badvaddr_q, count_q, compare_q, status_q, cause_q, epc_q;
  logic [31:0] badvaddr_d, count_d, compare_d, status_d, cause_d, epc_d;
  logic        div_q, div_d;
  logic        exc_taken;
  logic [4:0]  exc_code;
  bva_sel_t    bva_sel;
  logic        count_tick;

  // Exception priority resolution; Eret is handled separately below
  always_comb begin
    exc_taken = 1'b1;
    exc_code  = 5'h00;
    bva_sel   = BVA_KEEP;
    if (ExceptType_i.Interrupt) begin
      exc_code = 5'h00;
    end else if (ExceptType_i.WrongAddressinIF) begin
      exc_code = 5'h04;
      bva_sel  = BVA_PC;
    end else if (ExceptType_i.ReservedInstruction) begin
      exc_code = 5'h0a;
    end else if (ExceptType_i.Syscall) begin
      exc_code = 5'h08;
    end else if (ExceptType_i.Break) begin
      exc_code = 5'h09;
    end else if (ExceptType_i.Overflow) begin
      exc_code = 5'h0c;
    end else if (ExceptType_i.WrWrongAddressinMEM) begin
      exc_code = 5'h05;
      bva_sel  = BVA_DATA;
    end else if (ExceptType_i.RdWrongAddressinMEM) begin
      exc_code = 5'h04;
      bva_sel  = BVA_DATA;
    end else begin
      exc_taken = 1'b0;
    end
  end

  assign count_tick = (COUNT_DIV == 1) || div_q;

  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q;
    compare_d  = compare_q;
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    div_d      = (COUNT_DIV == 1) ? 1'b0 : ~div_q;

    if (count_tick) count_d = count_q + 32'd1;

    // MTC0 first; exception updates below overlay only the fields they own
    if (WB_CP0RegWr_i) begin
      case (WB_CP0RegWrAddr_i)
        REG_COUNT:   count_d   = WB_CP0RegWrData_i;
        REG_COMPARE: compare_d = WB_CP0RegWrData_i;
        REG_STATUS:  status_d  = (status_q & ~STATUS_WMASK) | (WB_CP0RegWrData_i & STATUS_WMASK);
        REG_CAUSE:   cause_d   = (cause_q & ~CAUSE_WMASK) | (WB_CP0RegWrData_i & CAUSE_WMASK);
        REG_EPC:     epc_d     = WB_CP0RegWrData_i;
        default: ;
      endcase
    end

    if (WB_CP0RegWr_i && WB_CP0RegWrAddr_i == REG_COMPARE)
      cause_d[30] = 1'b0;
    else if (count_q == compare_q && compare_q != 32'd0)
      cause_d[30] = 1'b1;

    cause_d[15:10] = {Interrupt_i[5] | cause_q[30], Interrupt_i[4:0]};

    if (exc_taken) begin
      status_d[1]  = 1'b1;
      cause_d[6:2] = exc_code;
      if (!status_q[1]) begin
        epc_d       = IsInDelaySlot_i ? CurrentPC_i - 32'd4 : CurrentPC_i;
        cause_d[31] = IsInDelaySlot_i;
      end
      case (bva_sel)
        BVA_PC:   badvaddr_d = CurrentPC_i;
        BVA_DATA: badvaddr_d = BadVAddr_i;
        default: ;
      endcase
    end else if (ExceptType_i.Eret) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      status_q   <= STATUS_RST;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
      div_q      <= 1'b0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      div_q      <= div_d;
    end
  end

  always_comb begin
    CP0RegRdData_o = 32'd0;
    case (CP0RegRdAddr_i)
      REG_BADVADDR: CP0RegRdData_o = badvaddr_q;
      REG_COUNT:    CP0RegRdData_o = count_q;
      REG_COMPARE:  CP0RegRdData_o = compare_q;
      REG_STATUS:   CP0RegRdData_o = status_q;
      REG_CAUSE:    CP0RegRdData_o = cause_q;
      REG_EPC:      CP0RegRdData_o = epc_q;
      default: ;
    endcase
  end

  assign CP0Status_o   = status_q;
  assign CP0Cause_o    = cause_q;
  assign CP0EPC_o      = epc_q;
  assign CP0BadVAddr_o = badvaddr_q;
  assign Timer_int_o   = cause_q[30];

endmodule
